// File: rtl/taxi_pcie_us_msi_pkg.sv
// taxi_pcie_us_msi_pkg: shared types and constants for the MSI responder
package taxi_pcie_us_msi_pkg;
  typedef enum logic [1:0] {OK, FAIL_DIS, FAIL_RANGE, FAIL_MASK} msi_verdict_t;
  typedef enum logic [1:0] {IDLE, WAIT, EMIT} state_t;
  localparam int MSI_VEC_CNT = 32;
endpackage

// File: rtl/taxi_pcie_us_msi_prio_enc.sv
// taxi_pcie_us_msi_prio_enc: lowest-set-bit encoder over the MSI request vector
module taxi_pcie_us_msi_prio_enc import taxi_pcie_us_msi_pkg::*; (
  input  logic [MSI_VEC_CNT-1:0] vec,
  output logic [4:0]             idx,
  output logic                   valid
);
  always_comb begin
    idx = '0;
    for (int i = MSI_VEC_CNT - 1; i >= 0; i--) idx = vec[i] ? 5'(i) : idx;
  end
  assign valid = |vec;
endmodule

// File: rtl/taxi_pcie_us_msi_resp.sv
// taxi_pcie_us_msi_resp: UltraScale PCIe MSI responder emitting delivered interrupts as write events
module taxi_pcie_us_msi_resp import taxi_pcie_us_msi_pkg::*; #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_msi_en,
  input  logic [2:0]        host_msi_mme,
  input  logic [31:0]       host_msi_mask,
  input  logic [ADDR_W-1:0] host_msi_addr,
  input  logic [15:0]       host_msi_data,
  output logic [3:0]        cfg_interrupt_msi_enable,
  output logic [11:0]       cfg_interrupt_msi_mmenable,
  output logic              cfg_interrupt_msi_mask_update,
  input  logic [1:0]        cfg_interrupt_msi_select,
  output logic [31:0]       cfg_interrupt_msi_data,
  input  logic [31:0]       cfg_interrupt_msi_int,
  input  logic [31:0]       cfg_interrupt_msi_pending_status,
  input  logic              cfg_interrupt_msi_pending_status_data_enable,
  input  logic [1:0]        cfg_interrupt_msi_pending_status_function_num,
  output logic              cfg_interrupt_msi_sent,
  output logic              cfg_interrupt_msi_fail,
  output logic              m_msi_valid,
  input  logic              m_msi_ready,
  output logic [ADDR_W-1:0] m_msi_addr,
  output logic [31:0]       m_msi_data,
  output logic [31:0]       pending
);
  logic              en_q;
  logic [2:0]        mme_q;
  logic [31:0]       mask_q, mask_shadow;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q, lo_mask;
  state_t            state, state_nxt;
  msi_verdict_t      verdict, verdict_nxt;
  logic [3:0]        cnt;
  logic [4:0]        vec, req_idx;
  logic              req_valid, busy_rej, rej, defer, main_fail, main_sent, pend_load;

  taxi_pcie_us_msi_prio_enc u_enc (
    .vec   (cfg_interrupt_msi_int),
    .idx   (req_idx),
    .valid (req_valid)
  );

  assign verdict_nxt = !en_q ? FAIL_DIS :
                       ({3'b0, req_idx} >= (8'd1 << mme_q)) ? FAIL_RANGE :
                       mask_q[req_idx] ? FAIL_MASK : OK;
  assign busy_rej  = req_valid && state != IDLE;
  assign rej       = busy_rej || defer;
  assign lo_mask   = (16'd1 << mme_q) - 16'd1;
  assign pend_load = cfg_interrupt_msi_pending_status_data_enable && cfg_interrupt_msi_pending_status_function_num == 2'd0;

  assign cfg_interrupt_msi_enable   = {3'b0, en_q};
  assign cfg_interrupt_msi_mmenable = {9'b0, mme_q};
  assign cfg_interrupt_msi_data     = cfg_interrupt_msi_select == 2'd0 ? mask_q : 32'h0;
  assign m_msi_valid                = state == EMIT;

  always_comb begin
    state_nxt = state;
    main_fail = 1'b0;
    main_sent = 1'b0;
    if (state == IDLE && req_valid) state_nxt = WAIT;
    if (state == WAIT && cnt == '0) begin
      state_nxt = verdict == OK ? EMIT : IDLE;
      main_fail = verdict != OK;
    end
    if (state == EMIT && m_msi_ready) begin
      state_nxt = IDLE;
      main_sent = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q                          <= 1'b0;
      mme_q                         <= '0;
      mask_q                        <= '0;
      mask_shadow                   <= '0;
      addr_q                        <= '0;
      data_q                        <= '0;
      cfg_interrupt_msi_mask_update <= 1'b0;
      state                         <= IDLE;
      verdict                       <= OK;
      cnt                           <= '0;
      vec                           <= '0;
      defer                         <= 1'b0;
      cfg_interrupt_msi_fail        <= 1'b0;
      cfg_interrupt_msi_sent        <= 1'b0;
      m_msi_addr                    <= '0;
      m_msi_data                    <= '0;
      pending                       <= '0;
    end else begin
      en_q                          <= host_msi_en;
      mme_q                         <= host_msi_mme;
      mask_q                        <= host_msi_mask;
      addr_q                        <= host_msi_addr;
      data_q                        <= host_msi_data;
      mask_shadow                   <= mask_q;
      cfg_interrupt_msi_mask_update <= mask_q != mask_shadow;
      state                         <= state_nxt;
      if (state == IDLE && req_valid) begin
        vec     <= req_idx;
        verdict <= verdict_nxt;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == WAIT && cnt == '0 && verdict == OK) begin
        m_msi_addr <= addr_q;
        m_msi_data <= {16'h0, (data_q & ~lo_mask) | (16'(vec) & lo_mask)};
      end
      // a busy reject that lands on an in-flight pulse slips one cycle
      cfg_interrupt_msi_fail <= main_fail || (rej && !(main_fail || main_sent));
      cfg_interrupt_msi_sent <= main_sent;
      defer                  <= rej && (main_fail || main_sent);
      if (pend_load) pending <= cfg_interrupt_msi_pending_status;
      else if (main_fail && verdict == FAIL_MASK) pending[vec] <= 1'b1;
      else if (main_sent) pending[vec] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_taxi_pcie_us_msi_resp.sv
// tb_taxi_pcie_us_msi_resp: randomized self-checking bench against a spec-level MSI model
module tb_taxi_pcie_us_msi_resp;
  import taxi_pcie_us_msi_pkg::*;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_en = 1'b0;
  logic [2:0]  host_mme = '0;
  logic [31:0] host_mask = '0;
  logic [63:0] host_addr = '0;
  logic [15:0] host_data = '0;
  logic [3:0]  msi_enable;
  logic [11:0] msi_mmenable;
  logic        mask_update;
  logic [1:0]  msi_select = '0;
  logic [31:0] msi_rdata;
  logic [31:0] msi_int = '0;
  logic [31:0] ps = '0;
  logic        pde = 1'b0;
  logic [1:0]  pfn = '0;
  logic        sent, fail, valid;
  logic        ready = 1'b0;
  logic [63:0] ev_addr;
  logic [31:0] ev_data, pending;

  int checks = 0;
  int errors = 0;

  logic        cen;
  logic [2:0]  cmme;
  logic [31:0] cmask, exp_pend;
  logic [15:0] cdata;
  logic [63:0] caddr;

  taxi_pcie_us_msi_resp #(.LATENCY(L), .ADDR_W(64)) dut (
    .clk                                          (clk),
    .rst                                          (rst),
    .host_msi_en                                  (host_en),
    .host_msi_mme                                 (host_mme),
    .host_msi_mask                                (host_mask),
    .host_msi_addr                                (host_addr),
    .host_msi_data                                (host_data),
    .cfg_interrupt_msi_enable                     (msi_enable),
    .cfg_interrupt_msi_mmenable                   (msi_mmenable),
    .cfg_interrupt_msi_mask_update                (mask_update),
    .cfg_interrupt_msi_select                     (msi_select),
    .cfg_interrupt_msi_data                       (msi_rdata),
    .cfg_interrupt_msi_int                        (msi_int),
    .cfg_interrupt_msi_pending_status             (ps),
    .cfg_interrupt_msi_pending_status_data_enable (pde),
    .cfg_interrupt_msi_pending_status_function_num(pfn),
    .cfg_interrupt_msi_sent                       (sent),
    .cfg_interrupt_msi_fail                       (fail),
    .m_msi_valid                                  (valid),
    .m_msi_ready                                  (ready),
    .m_msi_addr                                   (ev_addr),
    .m_msi_data                                   (ev_data),
    .pending                                      (pending)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && (sent || fail)) begin
      checks++;
      if (sent && fail) begin
        errors++;
        $display("FAIL sent_fail_exclusive: sent=%0b fail=%0b, required not both high", sent, fail);
      end
    end
  end

  function automatic msi_verdict_t model_verdict(input int v);
    if (!cen) return FAIL_DIS;
    if (v >= (1 << cmme)) return FAIL_RANGE;
    if (cmask[v]) return FAIL_MASK;
    return OK;
  endfunction

  function automatic logic [31:0] model_data(input int v);
    int n, val;
    n = 1 << cmme;
    val = (int'(cdata) / n) * n + (v % n);
    return {16'h0, 16'(val)};
  endfunction

  task automatic set_cfg(input logic e, input logic [2:0] m, input logic [31:0] mk, input logic [15:0] d, input logic [63:0] a);
    @(negedge clk);
    host_en = e; host_mme = m; host_mask = mk; host_data = d; host_addr = a;
    cen = e; cmme = m; cmask = mk; cdata = d; caddr = a;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_pend(input logic [31:0] val, input logic [1:0] fn);
    @(negedge clk);
    ps = val; pde = 1'b1; pfn = fn;
    @(negedge clk);
    pde = 1'b0;
    if (fn == 2'd0) exp_pend = val;
    checks++;
    if (pending !== exp_pend) begin
      errors++;
      $display("FAIL pending_load fn=%0d: got %08h, required %08h", fn, pending, exp_pend);
    end
  endtask

  task automatic run_req(input int v, input logic [31:0] hi, input int rd);
    msi_verdict_t ev;
    logic [31:0] ed;
    int k;
    bit done;
    ev = model_verdict(v);
    ed = model_data(v);
    @(negedge clk);
    msi_int = (32'h1 << v) | (hi << (v + 1));
    k = 0;
    done = 0;
    while (!done && k < L + 6) begin
      @(negedge clk);
      msi_int = '0;
      k++;
      if (fail || valid) done = 1;
    end
    checks++;
    if (!done || k != L + 1 || fail !== (ev != OK)) begin
      errors++;
      $display("FAIL req_outcome v=%0d: event=%0b cycle %0d fail=%0b, required cycle %0d fail=%0b", v, done, k, fail, L + 1, ev != OK);
    end
    if (ev == FAIL_MASK) exp_pend[v] = 1'b1;
    checks++;
    if (pending !== exp_pend) begin
      errors++;
      $display("FAIL req_pending v=%0d: got %08h, required %08h", v, pending, exp_pend);
    end
    if (ev == OK && done) begin
      checks++;
      if (ev_addr !== caddr || ev_data !== ed) begin
        errors++;
        $display("FAIL event_fields v=%0d: got %016h/%08h, required %016h/%08h", v, ev_addr, ev_data, caddr, ed);
      end
      repeat (rd) @(negedge clk);
      checks++;
      if (valid !== 1'b1 || ev_data !== ed || sent !== 1'b0) begin
        errors++;
        $display("FAIL event_hold v=%0d: valid=%0b data=%08h sent=%0b, required 1/%08h/0", v, valid, ev_data, sent, ed);
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      exp_pend[v] = 1'b0;
      checks++;
      if (sent !== 1'b1 || valid !== 1'b0 || pending !== exp_pend) begin
        errors++;
        $display("FAIL handshake v=%0d: sent=%0b valid=%0b pending=%08h, required 1/0/%08h", v, sent, valid, pending, exp_pend);
      end
    end
    @(negedge clk);
    checks++;
    if (fail !== 1'b0 || sent !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width v=%0d: sent=%0b fail=%0b, required 0/0", v, sent, fail);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (valid !== 0 || sent !== 0 || fail !== 0 || pending !== 0 || msi_enable !== 0 ||
        msi_mmenable !== 0 || msi_rdata !== 0 || mask_update !== 0 || ev_addr !== 0 || ev_data !== 0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b sent=%0b fail=%0b pending=%08h en=%0h mme=%0h, required all 0",
               valid, sent, fail, pending, msi_enable, msi_mmenable);
    end
    rst = 1'b0;
    exp_pend = '0;
  endtask

  task automatic test_cfg;
    set_cfg(1'b1, 3'd3, 32'hA5A5_0F0F, 16'h1234, 64'h1);
    msi_select = 2'd0;
    #1;
    checks++;
    if (msi_enable !== 4'h1 || msi_mmenable !== 12'h3 || msi_rdata !== 32'hA5A5_0F0F) begin
      errors++;
      $display("FAIL cfg_readback: en=%0h mme=%0h data=%08h, required 1/3/a5a50f0f", msi_enable, msi_mmenable, msi_rdata);
    end
    msi_select = 2'd1;
    #1;
    checks++;
    if (msi_rdata !== 32'h0) begin
      errors++;
      $display("FAIL cfg_select1: data=%08h, required 0", msi_rdata);
    end
    msi_select = 2'd0;
  endtask

  task automatic test_deliver;
    set_cfg(1'b1, 3'd5, 32'h0, 16'h4000, 64'hFEE0_0000);
    checks++;
    if (model_data(3) !== 32'h0000_4003) begin
      errors++;
      $display("FAIL model_data: got %08h, required 00004003", model_data(3));
    end
    run_req(3, $urandom, 2);
    run_req(31, 32'h0, 0);
  endtask

  task automatic test_disabled;
    set_cfg(1'b0, 3'd5, 32'h0, 16'h4000, 64'hFEE0_0000);
    run_req(0, 32'h0, 0);
  endtask

  task automatic test_range;
    set_cfg(1'b1, 3'd2, 32'h0, 16'h4000, 64'hFEE0_0000);
    run_req(5, 32'h0, 0);
    run_req(2, 32'h0, 1);
    run_req(4, 32'h0, 0);
  endtask

  task automatic test_mask;
    int cnt;
    @(negedge clk);
    host_mask = 32'h10; cmask = 32'h10;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (mask_update) cnt++;
    end
    checks++;
    if (cnt != 1) begin
      errors++;
      $display("FAIL mask_update_set: pulses=%0d, required 1", cnt);
    end
    run_req(4, 32'h0, 0);
    @(negedge clk);
    host_mask = 32'h0; cmask = 32'h0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (mask_update) cnt++;
    end
    checks++;
    if (cnt != 1) begin
      errors++;
      $display("FAIL mask_update_clr: pulses=%0d, required 1", cnt);
    end
    load_pend(32'hFFFF_FFFF, 2'd1);
    load_pend(32'h0, 2'd0);
  endtask

  task automatic test_busy;
    int k;
    int bad;
    set_cfg(1'b1, 3'd5, 32'h0, 16'h1234, 64'hFEE0_1000);
    @(negedge clk);
    msi_int = 32'h2;
    k = 0;
    bad = 0;
    while (!valid && k < L + 6) begin
      @(negedge clk);
      k++;
      msi_int = (k == 2) ? 32'h4 : 32'h0;
      if (fail !== (k == 3)) bad++;
    end
    checks++;
    if (bad != 0 || k != L + 1) begin
      errors++;
      $display("FAIL busy_reject: wrong fail cycles=%0d valid at %0d, required 0 and %0d", bad, k, L + 1);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (sent !== 1'b0 || valid !== 1'b1) bad++;
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (bad != 0 || sent !== 1'b1 || ev_data !== model_data(1)) begin
      errors++;
      $display("FAIL busy_first_sent: stall errors=%0d sent=%0b data=%08h, required 0/1/%08h", bad, sent, ev_data, model_data(1));
    end
    @(negedge clk);
    msi_int = 32'h40;
    k = 0;
    while (!valid && k < L + 6) begin
      @(negedge clk);
      msi_int = '0;
      k++;
    end
    msi_int = 32'h80;
    ready = 1'b1;
    @(negedge clk);
    msi_int = '0;
    ready = 1'b0;
    checks++;
    if (sent !== 1'b1 || fail !== 1'b0) begin
      errors++;
      $display("FAIL collide_sent: sent=%0b fail=%0b, required 1/0", sent, fail);
    end
    @(negedge clk);
    checks++;
    if (sent !== 1'b0 || fail !== 1'b1) begin
      errors++;
      $display("FAIL collide_deferred: sent=%0b fail=%0b, required 0/1", sent, fail);
    end
    @(negedge clk);
    checks++;
    if (fail !== 1'b0) begin
      errors++;
      $display("FAIL collide_single: fail=%0b, required 0", fail);
    end
  endtask

  task automatic test_reset_emit;
    int k;
    int bad;
    set_cfg(1'b1, 3'd5, 32'h0, 16'h8000, 64'hFEE0_2000);
    @(negedge clk);
    msi_int = 32'h200;
    k = 0;
    while (!valid && k < L + 6) begin
      @(negedge clk);
      msi_int = '0;
      k++;
    end
    ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_emit_valid: valid=%0b (reached at cycle %0d), required 0", valid, k);
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (sent || fail) bad++;
    end
    rst = 1'b0;
    exp_pend = '0;
    repeat (2) begin
      @(negedge clk);
      if (sent || fail) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_emit_pulse: pulses=%0d, required 0", bad);
    end
    run_req(9, 32'h0, 1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      set_cfg($urandom_range(0, 7) != 0, 3'($urandom_range(0, 5)), $urandom & $urandom & $urandom,
              16'($urandom), {$urandom, $urandom});
      if ($urandom_range(0, 4) == 0) load_pend($urandom & $urandom, 2'($urandom_range(0, 1)));
      run_req($urandom_range(0, 31), $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset;
    test_cfg;
    test_deliver;
    test_disabled;
    test_range;
    test_mask;
    test_busy;
    test_reset_emit;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/taxi_pcie_us_msi_resp.md
Name: taxi_pcie_us_msi_resp

Overview:
- Synthesizable responder for the UltraScale PCIe hard-IP MSI interrupt interface; it is the core-side end of the cfg_interrupt_msi_* port that fpga_core drives.
- Used in simulation and loopback builds in place of the hard IP. It accepts MSI requests, checks the host-programmed enable, vector-count and mask state, and returns sent or fail.
- Each delivered interrupt is emitted as a memory-write event (addr, data) on a valid/ready stream, for a host model or checker.

Parameters:
- LATENCY, 4: cycles from request accept to the sent/fail pulse for the fail paths, and to the event presentation for delivery; legal range 1..15.
- ADDR_W, 64: MSI address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- host_msi_en  in  1  host MSI enable (function 0)
- host_msi_mme  in  3  host Multiple Message Enable; log2 of the number of allowed vectors, legal 0..5
- host_msi_mask  in  32  host per-vector mask
- host_msi_addr  in  ADDR_W  MSI target address
- host_msi_data  in  16  MSI data base value
- cfg_interrupt_msi_enable  out  4  bit0 = registered host_msi_en; bits 3:1 = 0
- cfg_interrupt_msi_mmenable  out  12  bits 2:0 = host_msi_mme; all other bits 0
- cfg_interrupt_msi_mask_update  out  1  one-cycle pulse when the mask changes
- cfg_interrupt_msi_select  in  2  function select for the data readback
- cfg_interrupt_msi_data  out  32  host_msi_mask when select==0, else 0
- cfg_interrupt_msi_int  in  32  request vector; one bit set, held for one cycle
- cfg_interrupt_msi_pending_status  in  32  pending bits supplied by the DUT
- cfg_interrupt_msi_pending_status_data_enable  in  1  load strobe for the pending bits
- cfg_interrupt_msi_pending_status_function_num  in  2  function for the pending load
- cfg_interrupt_msi_sent  out  1  success pulse
- cfg_interrupt_msi_fail  out  1  failure pulse
- m_msi_valid  out  1  event valid
- m_msi_ready  in  1  event ready
- m_msi_addr  out  ADDR_W  event address
- m_msi_data  out  32  event data
- pending  out  32  internal pending register, for the testbench

Behaviour:
- Reset values: all outputs 0; state IDLE; pending = 0; mask shadow register = 0.
- Config path:
  - host_* inputs are registered, 1 cycle of latency to the cfg_* outputs.
  - mask_update pulses for 1 cycle in the cycle after the registered mask changes; one pulse per changed cycle.
- State IDLE:
  - On msi_int != 0, take vector v = index of the lowest set bit; any additional set bits are ignored.
  - Latch v, and latch the verdict using config sampled in the same cycle, in this priority order:
    - FAIL_DIS: en==0
    - FAIL_RANGE: v >= (1<<mme)
    - FAIL_MASK: mask[v]==1
    - OK
  - Load the LATENCY counter and go to WAIT.
- State WAIT:
  - Counter decrements each cycle.
  - At 0: a FAIL verdict pulses fail for 1 cycle and returns to IDLE; OK goes to EMIT.
  - FAIL_MASK also sets pending[v] in the same cycle as the fail pulse.
- State EMIT:
  - Output fields:
    - m_msi_valid = 1
    - m_msi_addr = host_msi_addr
    - m_msi_data = {16'h0, data_base with the low mme bits replaced by v[mme-1:0]}
  - Hold all fields stable until m_msi_ready.
  - On the handshake: pulse sent for 1 cycle, clear pending[v], return to IDLE.
- Request while busy (state != IDLE): not queued. Fail pulses 1 cycle later; the in-flight request is unaffected.
  - If that fail pulse collides with the in-flight fail or sent pulse, the busy-reject fail is deferred 1 cycle.
  - At most one deferred reject is held; further rejects in that window are dropped.
- Pending load: data_enable with function_num==0 overwrites pending with pending_status. It takes priority over the set/clear of pending in the same cycle.
- Config changes during WAIT or EMIT do not alter the latched verdict. The address and data fields are latched on entry to EMIT.
- Asynchronous reset at any point returns to IDLE; a dropped in-flight request produces no pulse.
- sent and fail are never high in the same cycle.

Decomposition:
- Shared package taxi_pcie_us_msi_pkg holds:
  - typedef msi_verdict_t {OK, FAIL_DIS, FAIL_RANGE, FAIL_MASK}
  - typedef state_t {IDLE, WAIT, EMIT}
  - MSI_VEC_CNT = 32
- Sub-module taxi_pcie_us_msi_prio_enc: 32-bit lowest-set-bit encoder with a valid output.

Test Plan:
- en=1, mme=5, mask=0, data=16'h4000, addr=0xFEE0_0000; int bit 3 -> event addr 0xFEE00000, data 0x00004003; sent 1 cycle after handshake; first valid LATENCY+1 cycles after request.
- en=0; int bit 0 -> fail exactly LATENCY+1 cycles after request; no event; pending unchanged.
- mme=2; int bit 5 -> fail (range); int bit 2 with data=16'h4000 -> data 0x4002.
- mask=0x10; int bit 4 -> fail, pending==0x10; clear mask, load pending=0 via data_enable -> pending==0; mask_update pulses once per change.
- Request, then a second request while in WAIT with m_msi_ready held low 10 cycles -> second request fails, sent for the first only after ready; never sent and fail together.
- Assert rst while in EMIT -> valid drops immediately, no sent; next request completes normally.
